controlador_msi_snoop: RTL and testbench

// - Sequential, parametrised MSI snooping coherence controller for one processor's direct-mapped cache (NUM_LINES lines).
// - Holds per-line state and tag, serves CPU requests, arbitrates for and drives the shared snoop bus, and reacts to other controllers' bus messages.
// - Sits between the CPU request port and the bus arbiter; one instance per processor.

---
 rtl/controlador_msi_snoop.sv | 257 +++++++++++++++++++++++++
 tb/tb_controlador_msi_snoop.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_msi_snoop.sv
// controlador_msi_snoop: MSI snooping coherence controller for one direct-mapped cache.
// Define STATS_EN to add saturating hit_count/miss_count outputs.
module controlador_msi_snoop #(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 4,
  localparam int IDX_W    = $clog2(NUM_LINES),
  localparam int AW       = TAG_W + IDX_W
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cpu_valid,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ready,
  output logic          cpu_hit,
  output logic          bus_req,
  input  logic          bus_gnt,
  output logic [1:0]    bus_msg_out,
  output logic [AW-1:0] bus_addr_out,
  input  logic [1:0]    bus_msg_in,
  input  logic [AW-1:0] bus_addr_in,
  output logic          write_back,
  output logic [AW-1:0] wb_addr,
  output logic          abort_mem,
  output logic          busy
`ifdef STATS_EN
  ,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_ARB,
    S_GRANT,
    S_DONE
  } state_e;

  localparam logic [1:0] L_INV  = 2'b00;
  localparam logic [1:0] L_MOD  = 2'b01;
  localparam logic [1:0] L_SHR  = 2'b10;

  localparam logic [1:0] M_INV  = 2'b00;
  localparam logic [1:0] M_RDM  = 2'b01;
  localparam logic [1:0] M_WRM  = 2'b10;
  localparam logic [1:0] M_NONE = 2'b11;

  state_e state_q, state_d;
  logic          req_wr_q, req_wr_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic          hit_q, hit_d;

  logic [NUM_LINES-1:0][1:0]       st_q, st_d;
  logic [NUM_LINES-1:0][TAG_W-1:0] tag_q, tag_d;

  logic          snp_wb_q, snp_wb_d;
  logic          snp_abort_q, snp_abort_d;
  logic [AW-1:0] snp_addr_q, snp_addr_d;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] snp_idx;
  logic [TAG_W-1:0] snp_tag;

  assign req_idx = req_addr_q[IDX_W-1:0];
  assign req_tag = req_addr_q[AW-1:IDX_W];
  assign snp_idx = bus_addr_in[IDX_W-1:0];
  assign snp_tag = bus_addr_in[AW-1:IDX_W];

  logic [1:0] snp_cur;
  logic [1:0] snp_new;
  logic       snp_act;
  logic       snp_pulse;

  // Own message is on the bus during GRANT, so snooping is suppressed there.
  always_comb begin
    snp_cur   = st_q[snp_idx];
    snp_new   = snp_cur;
    snp_act   = 1'b0;
    snp_pulse = 1'b0;
    if (state_q != S_GRANT && bus_msg_in != M_NONE &&
        tag_q[snp_idx] == snp_tag) begin
      unique case (1'b1)
        snp_cur == L_MOD && bus_msg_in == M_RDM: begin
          snp_new   = L_SHR;
          snp_act   = 1'b1;
          snp_pulse = 1'b1;
        end
        snp_cur == L_MOD && bus_msg_in == M_WRM: begin
          snp_new   = L_INV;
          snp_act   = 1'b1;
          snp_pulse = 1'b1;
        end
        snp_cur == L_SHR &&
        (bus_msg_in == M_INV || bus_msg_in == M_WRM): begin
          snp_new = L_INV;
          snp_act = 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [1:0] cur_st;
  logic [1:0] eff_st;
  logic       tag_hit;
  logic       lookup_hit;
  logic       grant_wb;
  logic       grant_inv;

  // Lookup sees the line as it will be after a concurrent snoop.
  always_comb begin
    cur_st  = st_q[req_idx];
    eff_st  = (snp_act && snp_idx == req_idx) ? snp_new : cur_st;
    tag_hit = (tag_q[req_idx] == req_tag);
    if (req_wr_q) begin
      lookup_hit = tag_hit && eff_st == L_MOD;
    end else begin
      lookup_hit = tag_hit && (eff_st == L_MOD || eff_st == L_SHR);
    end
    grant_wb  = (state_q == S_GRANT) && cur_st == L_MOD;
    grant_inv = req_wr_q && tag_hit && cur_st == L_SHR;
  end

  always_comb begin
    state_d    = state_q;
    req_wr_d   = req_wr_q;
    req_addr_d = req_addr_q;
    hit_d      = hit_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_valid) begin
          req_wr_d   = cpu_write;
          req_addr_d = cpu_addr;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d   = lookup_hit;
        state_d = lookup_hit ? S_DONE : S_ARB;
      end
      S_ARB: begin
        if (bus_gnt) begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    st_d  = st_q;
    tag_d = tag_q;
    if (snp_act) begin
      st_d[snp_idx] = snp_new;
    end
    if (state_q == S_GRANT) begin
      st_d[req_idx]  = req_wr_q ? L_MOD : L_SHR;
      tag_d[req_idx] = req_tag;
    end
  end

  // A snoop write-back colliding with a grant eviction is held one cycle.
  always_comb begin
    snp_wb_d    = snp_pulse | (snp_wb_q & grant_wb);
    snp_abort_d = snp_pulse;
    snp_addr_d  = snp_pulse ? bus_addr_in : snp_addr_q;
  end

  always_comb begin
    cpu_ready    = (state_q == S_DONE);
    cpu_hit      = (state_q == S_DONE) && hit_q;
    bus_req      = (state_q == S_ARB) || (state_q == S_GRANT);
    busy         = (state_q != S_IDLE);
    bus_msg_out  = M_NONE;
    bus_addr_out = '0;
    if (state_q == S_GRANT) begin
      bus_addr_out = req_addr_q;
      if (!req_wr_q) begin
        bus_msg_out = M_RDM;
      end else if (grant_inv) begin
        bus_msg_out = M_INV;
      end else begin
        bus_msg_out = M_WRM;
      end
    end
    write_back = grant_wb | snp_wb_q;
    if (grant_wb) begin
      wb_addr = {tag_q[req_idx], req_idx};
    end else if (snp_wb_q) begin
      wb_addr = snp_addr_q;
    end else begin
      wb_addr = '0;
    end
    abort_mem = snp_abort_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      hit_q       <= 1'b0;
      st_q        <= '0;
      tag_q       <= '0;
      snp_wb_q    <= 1'b0;
      snp_abort_q <= 1'b0;
      snp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      hit_q       <= hit_d;
      st_q        <= st_d;
      tag_q       <= tag_d;
      snp_wb_q    <= snp_wb_d;
      snp_abort_q <= snp_abort_d;
      snp_addr_q  <= snp_addr_d;
    end
  end

`ifdef STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_DONE) begin
      if (hit_q && hit_cnt_q != 16'hFFFF) begin
        hit_cnt_d = hit_cnt_q + 16'd1;
      end
      if (!hit_q && miss_cnt_q != 16'hFFFF) begin
        miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_controlador_msi_snoop.sv
// tb_controlador_msi_snoop: directed vector table, hand-written corner
// sequences and random traffic checked against a line-level MSI model.
module tb_controlador_msi_snoop;

  logic       clock;
  logic       resetn;
  logic       cpu_valid;
  logic       cpu_write;
  logic [5:0] cpu_addr;
  logic       cpu_ready;
  logic       cpu_hit;
  logic       bus_req;
  logic       bus_gnt;
  logic [1:0] bus_msg_out;
  logic [5:0] bus_addr_out;
  logic [1:0] bus_msg_in;
  logic [5:0] bus_addr_in;
  logic       write_back;
  logic [5:0] wb_addr;
  logic       abort_mem;
  logic       busy;
`ifdef STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  controlador_msi_snoop #(.NUM_LINES(4), .TAG_W(4)) dut (
    .clock(clock),
    .resetn(resetn),
    .cpu_valid(cpu_valid),
    .cpu_write(cpu_write),
    .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready),
    .cpu_hit(cpu_hit),
    .bus_req(bus_req),
    .bus_gnt(bus_gnt),
    .bus_msg_out(bus_msg_out),
    .bus_addr_out(bus_addr_out),
    .bus_msg_in(bus_msg_in),
    .bus_addr_in(bus_addr_in),
    .write_back(write_back),
    .wb_addr(wb_addr),
    .abort_mem(abort_mem),
    .busy(busy)
`ifdef STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] A(input int t, input int i);
    return 6'(t * 4 + i);
  endfunction

  // Line-level reference: states and tags per index, plus counters.
  typedef enum int { MI, MM, MS } mst_e;
  mst_e m_st[4];
  int   m_tag[4];
  int   m_hits;
  int   m_misses;

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_st[i]  = MI;
      m_tag[i] = 0;
    end
    m_hits   = 0;
    m_misses = 0;
  endfunction

  function automatic bit m_snoop(input logic [1:0] msg, input logic [5:0] a);
    int i = int'(a[1:0]);
    int t = int'(a[5:2]);
    bit wb = 0;
    if (msg == 2'b11 || m_tag[i] != t || m_st[i] == MI) return 0;
    if (m_st[i] == MM && msg == 2'b01) begin
      m_st[i] = MS;
      wb = 1;
    end else if (m_st[i] == MM && msg == 2'b10) begin
      m_st[i] = MI;
      wb = 1;
    end else if (m_st[i] == MS && msg != 2'b01) begin
      m_st[i] = MI;
    end
    return wb;
  endfunction

  int         exp_lat, exp_reqs, exp_msgs, exp_aborts;
  bit         exp_hit;
  logic [1:0] exp_msg;
  logic [5:0] exp_maddr;
  logic [5:0] exp_wb[$];

  function automatic void model_op(input bit wr, input logic [5:0] a,
                                   input int g, input logic [1:0] im,
                                   input logic [5:0] ia);
    int i = int'(a[1:0]);
    int t = int'(a[5:2]);
    exp_wb.delete();
    exp_aborts = 0;
    exp_msg    = 2'b11;
    exp_maddr  = a;
    exp_hit = (m_tag[i] == t) && (wr ? m_st[i] == MM : m_st[i] != MI);
    if (exp_hit) begin
      exp_lat  = 2;
      exp_reqs = 0;
      exp_msgs = 0;
      m_hits++;
    end else begin
      exp_lat  = 3 + g;
      exp_reqs = g + 1;
      exp_msgs = 1;
      if (im != 2'b11 && m_snoop(im, ia)) begin
        exp_wb.push_back(ia);
        exp_aborts = 1;
      end
      if (!wr) exp_msg = 2'b01;
      else if (m_st[i] == MS && m_tag[i] == t) exp_msg = 2'b00;
      else exp_msg = 2'b10;
      if (m_st[i] == MM) exp_wb.push_back(A(m_tag[i], i));
      m_st[i]  = wr ? MM : MS;
      m_tag[i] = t;
      m_misses++;
    end
  endfunction

  int         obs_lat, obs_reqs, obs_msgs, obs_aborts;
  bit         obs_hit, obs_timeout, obs_busy;
  logic [1:0] obs_msg;
  logic [5:0] obs_maddr;
  logic [5:0] obs_wb[$];

  // One CPU request; optional snoop injected on the first ARB cycle.
  task automatic run_op(input bit wr, input logic [5:0] a, input int g,
                        input bit drop, input logic [1:0] im,
                        input logic [5:0] ia);
    int  cyc = 0;
    bit  done = 0;
    obs_lat = 0; obs_reqs = 0; obs_msgs = 0; obs_aborts = 0;
    obs_hit = 0; obs_msg = 2'b11; obs_maddr = '0;
    obs_wb.delete();
    cpu_valid = 1'b1;
    cpu_write = wr;
    cpu_addr  = a;
    while (!done && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (drop && cyc == 1) cpu_valid = 1'b0;
      bus_msg_in = 2'b11;
      if (bus_req) begin
        obs_reqs++;
        if (obs_reqs == 1 && im != 2'b11) begin
          bus_msg_in  = im;
          bus_addr_in = ia;
        end
      end
      bus_gnt = bus_req && obs_reqs >= g;
      if (bus_msg_out != 2'b11) begin
        obs_msgs++;
        obs_msg   = bus_msg_out;
        obs_maddr = bus_addr_out;
      end
      if (write_back) obs_wb.push_back(wb_addr);
      if (abort_mem) obs_aborts++;
      if (cpu_ready) begin
        done    = 1;
        obs_lat = cyc;
        obs_hit = cpu_hit;
      end
    end
    obs_timeout = !done;
    cpu_valid  = 1'b0;
    bus_gnt    = 1'b0;
    bus_msg_in = 2'b11;
    @(negedge clock);
    if (write_back) obs_wb.push_back(wb_addr);
    if (abort_mem) obs_aborts++;
    obs_busy = busy;
  endtask

  task automatic compare_op(input string p);
    chk({p, ".timeout"}, obs_timeout, 0);
    chk({p, ".lat"}, obs_lat, exp_lat);
    chk({p, ".hit"}, obs_hit, exp_hit);
    chk({p, ".reqs"}, obs_reqs, exp_reqs);
    chk({p, ".msgs"}, obs_msgs, exp_msgs);
    if (exp_msgs != 0) begin
      chk({p, ".msg"}, obs_msg, exp_msg);
      chk({p, ".maddr"}, obs_maddr, exp_maddr);
    end
    chk({p, ".wb_n"}, obs_wb.size(), exp_wb.size());
    obs_wb.sort();
    exp_wb.sort();
    for (int k = 0; k < exp_wb.size() && k < obs_wb.size(); k++)
      chk({p, ".wb_addr"}, obs_wb[k], exp_wb[k]);
    chk({p, ".aborts"}, obs_aborts, exp_aborts);
    chk({p, ".busy_after"}, obs_busy, 0);
  endtask

  bit         obs_swb, obs_sab, obs_after;
  logic [5:0] obs_swa;

  task automatic run_snoop(input logic [1:0] msg, input logic [5:0] a);
    bus_msg_in  = msg;
    bus_addr_in = a;
    @(negedge clock);
    bus_msg_in = 2'b11;
    obs_swb = write_back;
    obs_sab = abort_mem;
    obs_swa = wb_addr;
    @(negedge clock);
    obs_after = write_back | abort_mem;
  endtask

  task automatic compare_snoop(input string p, input bit wb,
                               input logic [5:0] wba);
    chk({p, ".wb"}, obs_swb, wb);
    chk({p, ".abort"}, obs_sab, wb);
    if (wb) chk({p, ".wb_addr"}, obs_swa, wba);
    chk({p, ".one_cycle"}, obs_after, 0);
  endtask

  task automatic do_reset(input bit check);
    resetn     = 1'b0;
    cpu_valid  = 1'b0;
    bus_gnt    = 1'b0;
    bus_msg_in = 2'b11;
    @(negedge clock);
    @(negedge clock);
    if (check) begin
      chk("rst.cpu_ready", cpu_ready, 0);
      chk("rst.cpu_hit", cpu_hit, 0);
      chk("rst.bus_req", bus_req, 0);
      chk("rst.write_back", write_back, 0);
      chk("rst.abort_mem", abort_mem, 0);
      chk("rst.busy", busy, 0);
      chk("rst.bus_msg_out", bus_msg_out, 3);
      chk("rst.bus_addr_out", bus_addr_out, 0);
      chk("rst.wb_addr", wb_addr, 0);
    end
    resetn = 1'b1;
    m_reset();
  endtask

  typedef struct {
    bit         is_op;
    bit         wr;
    logic [1:0] msg;
    logic [5:0] addr;
    int         g;
    bit         e_hit;
    logic [1:0] e_msg;
    bit         e_wb;
    logic [5:0] e_wba;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk_op(input bit wr, input logic [5:0] a,
                                 input int g, input bit h,
                                 input logic [1:0] m, input bit wb,
                                 input logic [5:0] wba);
    vec_t v;
    v.is_op = 1; v.wr = wr; v.msg = 2'b11; v.addr = a; v.g = g;
    v.e_hit = h; v.e_msg = m; v.e_wb = wb; v.e_wba = wba;
    return v;
  endfunction

  function automatic vec_t mk_sn(input logic [1:0] m, input logic [5:0] a,
                                 input bit wb);
    vec_t v;
    v.is_op = 0; v.wr = 0; v.msg = m; v.addr = a; v.g = 0;
    v.e_hit = 0; v.e_msg = 2'b11; v.e_wb = wb; v.e_wba = a;
    return v;
  endfunction

  initial begin
    bit         wr, drop, sn;
    logic [5:0] a, ia;
    logic [1:0] im;
    int         g, waited;

    resetn = 1'b0; cpu_valid = 1'b0; cpu_write = 1'b0; cpu_addr = '0;
    bus_gnt = 1'b0; bus_msg_in = 2'b11; bus_addr_in = '0;
    do_reset(1);

    tbl.push_back(mk_op(0, A(1,3), 1, 0, 2'b01, 0, '0));
    tbl.push_back(mk_op(0, A(1,3), 1, 1, 2'b11, 0, '0));
    tbl.push_back(mk_op(1, A(1,3), 1, 0, 2'b00, 0, '0));
    tbl.push_back(mk_op(1, A(1,3), 1, 1, 2'b11, 0, '0));
    tbl.push_back(mk_sn(2'b01, A(1,3), 1));
    tbl.push_back(mk_sn(2'b10, A(1,3), 0));
    tbl.push_back(mk_op(0, A(1,3), 2, 0, 2'b01, 0, '0));
    tbl.push_back(mk_op(1, A(1,2), 1, 0, 2'b10, 0, '0));
    tbl.push_back(mk_op(0, A(2,2), 3, 0, 2'b01, 1, A(1,2)));
    tbl.push_back(mk_op(0, A(2,2), 1, 1, 2'b11, 0, '0));
    tbl.push_back(mk_sn(2'b00, A(1,3), 0));
    tbl.push_back(mk_op(0, A(1,3), 1, 0, 2'b01, 0, '0));
    tbl.push_back(mk_sn(2'b01, A(5,3), 0));
    tbl.push_back(mk_op(1, A(1,3), 1, 0, 2'b00, 0, '0));
    tbl.push_back(mk_sn(2'b00, A(1,3), 0));
    tbl.push_back(mk_op(1, A(1,3), 1, 1, 2'b11, 0, '0));
    tbl.push_back(mk_sn(2'b10, A(1,3), 1));
    tbl.push_back(mk_op(0, A(1,3), 1, 0, 2'b01, 0, '0));
    tbl.push_back(mk_op(0, A(0,0), 1, 0, 2'b01, 0, '0));

    foreach (tbl[k]) begin
      if (tbl[k].is_op) begin
        run_op(tbl[k].wr, tbl[k].addr, tbl[k].g, 0, 2'b11, '0);
        exp_hit    = tbl[k].e_hit;
        exp_lat    = tbl[k].e_hit ? 2 : 3 + tbl[k].g;
        exp_reqs   = tbl[k].e_hit ? 0 : tbl[k].g + 1;
        exp_msgs   = (tbl[k].e_msg != 2'b11) ? 1 : 0;
        exp_msg    = tbl[k].e_msg;
        exp_maddr  = tbl[k].addr;
        exp_aborts = 0;
        exp_wb.delete();
        if (tbl[k].e_wb) exp_wb.push_back(tbl[k].e_wba);
        compare_op($sformatf("vec%0d", k));
      end else begin
        run_snoop(tbl[k].msg, tbl[k].addr);
        compare_snoop($sformatf("vec%0d", k), tbl[k].e_wb, tbl[k].e_wba);
      end
    end

    // Shared line invalidated while the upgrade waits for the bus.
    do_reset(0);
    model_op(0, A(1,3), 1, 2'b11, '0);
    run_op(0, A(1,3), 1, 0, 2'b11, '0);
    compare_op("seq_fill");
    model_op(1, A(1,3), 2, 2'b00, A(1,3));
    run_op(1, A(1,3), 2, 0, 2'b00, A(1,3));
    compare_op("seq_inv_race");
    chk("seq_inv_race.write_miss", obs_msg, 2'b10);
    model_op(1, A(1,3), 1, 2'b11, '0);
    run_op(1, A(1,3), 1, 0, 2'b11, '0);
    compare_op("seq_after_race");
    model_op(0, A(2,1), 2, 2'b11, '0);
    run_op(0, A(2,1), 2, 1, 2'b11, '0);
    compare_op("seq_drop_valid");

    // Reset asserted while arbitrating.
    cpu_valid = 1'b1; cpu_write = 1'b1; cpu_addr = A(3,0);
    waited = 0;
    while (!bus_req && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    chk("seq_rst.arb_reached", bus_req, 1);
    resetn = 1'b0;
    cpu_valid = 1'b0;
    @(negedge clock);
    chk("seq_rst.bus_req", bus_req, 0);
    chk("seq_rst.busy", busy, 0);
    chk("seq_rst.cpu_ready", cpu_ready, 0);
    chk("seq_rst.write_back", write_back, 0);
    chk("seq_rst.bus_msg_out", bus_msg_out, 3);
`ifdef STATS_EN
    chk("seq_rst.hit_count", hit_count, 0);
    chk("seq_rst.miss_count", miss_count, 0);
`endif
    resetn = 1'b1;
    m_reset();
    model_op(1, A(1,3), 1, 2'b11, '0);
    run_op(1, A(1,3), 1, 0, 2'b11, '0);
    compare_op("seq_rst_lines_inv");

    do_reset(0);
    for (int n = 0; n < 200; n++) begin
      a  = A($urandom_range(0, 2), $urandom_range(0, 3));
      sn = ($urandom_range(0, 9) < 4);
      if (sn) begin
        im = 2'($urandom_range(0, 2));
        wr = m_snoop(im, a);
        run_snoop(im, a);
        compare_snoop($sformatf("rnd%0d", n), wr, a);
      end else begin
        wr   = 1'($urandom_range(0, 1));
        g    = $urandom_range(1, 3);
        drop = ($urandom_range(0, 4) == 0);
        im   = 2'b11;
        ia   = A($urandom_range(0, 2), $urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) im = 2'($urandom_range(0, 2));
        model_op(wr, a, g, im, ia);
        run_op(wr, a, g, drop, im, ia);
        compare_op($sformatf("rnd%0d", n));
      end
    end
`ifdef STATS_EN
    chk("stats.hits", hit_count, m_hits);
    chk("stats.misses", miss_count, m_misses);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
